// File: rtl/lcd_string_driver_if.sv
// 4-bit HD44780-style write bus between the string driver and the LCD.
interface lcd_string_driver_if;
  logic       lcd_rs;
  logic       lcd_w;
  logic       lcd_e;
  logic [3:0] data;

  modport master (output lcd_rs, output lcd_w, output lcd_e, output data);
  modport slave  (input  lcd_rs, input  lcd_w, input  lcd_e, input  data);
endinterface

// File: rtl/lcd_string_driver.sv
// Character LCD driver: one-time HD44780 4-bit initialisation, then endless
// two-line refresh from a per-frame snapshot of string1/string2.
module lcd_string_driver #(
  parameter int unsigned T_PWR  = 750000,
  parameter int unsigned T_4100 = 205000,
  parameter int unsigned T_100  = 5000,
  parameter int unsigned T_CMD  = 2000,
  parameter int unsigned T_CLR  = 82000,
  parameter int unsigned T_NIB  = 50,
  parameter int unsigned T_SU   = 2,
  parameter int unsigned T_E    = 12,
  parameter int unsigned T_HLD  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [127:0]               string1,
  input  logic [127:0]               string2,
  lcd_string_driver_if.master        lcd,
  output logic                       init_done,
  output logic                       frame_done
);

  // Wait counter must cover the longest interval, normally the power-up wait.
  localparam int unsigned T_M1  = (T_PWR  > T_4100) ? T_PWR : T_4100;
  localparam int unsigned T_M2  = (T_M1   > T_CLR ) ? T_M1  : T_CLR;
  localparam int unsigned T_M3  = (T_M2   > T_100 ) ? T_M2  : T_100;
  localparam int unsigned T_M4  = (T_M3   > T_CMD ) ? T_M3  : T_CMD;
  localparam int unsigned T_MAX = (T_M4   > T_NIB ) ? T_M4  : T_NIB;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  // Step states
  localparam logic [2:0] ST_PWR   = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_ADDR1 = 3'd3;
  localparam logic [2:0] ST_LINE1 = 3'd4;
  localparam logic [2:0] ST_ADDR2 = 3'd5;
  localparam logic [2:0] ST_LINE2 = 3'd6;

  // Phases within a step
  localparam logic [2:0] PH_SU   = 3'd0;
  localparam logic [2:0] PH_E    = 3'd1;
  localparam logic [2:0] PH_HLD  = 3'd2;
  localparam logic [2:0] PH_NIB  = 3'd3;
  localparam logic [2:0] PH_WAIT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          lo_q, lo_d;
  logic          init_done_q, init_done_d;
  logic          frame_done_q, frame_done_d;
  logic          lcd_e_q, lcd_e_d;
  logic          rs_q, rs_d;
  logic [3:0]    data_q, data_d;
  logic [127:0]  snap1_q, snap2_q;
  logic          snap_en;
  logic [7:0]    cur_byte, nxt_byte;
  logic [31:0]   phase_len;

  // Byte (or init nibble in the upper half) belonging to a given step.
  function automatic logic [7:0] byte_of(input logic [2:0]   st,
                                         input logic [3:0]   ix,
                                         input logic [127:0] s1,
                                         input logic [127:0] s2);
    logic [6:0] sh;
    sh = {~ix, 3'b000};
    case (st)
      ST_INIT:  byte_of = (ix == 4'd3) ? 8'h20 : 8'h30;
      ST_CMD: begin
        case (ix)
          4'd0:    byte_of = 8'h28;
          4'd1:    byte_of = 8'h06;
          4'd2:    byte_of = 8'h0C;
          default: byte_of = 8'h01;
        endcase
      end
      ST_ADDR1: byte_of = 8'h80;
      ST_ADDR2: byte_of = 8'hC0;
      ST_LINE1: byte_of = s1[sh +: 8];
      ST_LINE2: byte_of = s2[sh +: 8];
      default:  byte_of = 8'h00;
    endcase
  endfunction

  // Length of the current phase in cycles.
  always_comb begin
    cur_byte = byte_of(state_q, idx_q, snap1_q, snap2_q);
    case (ph_q)
      PH_SU:  phase_len = T_SU;
      PH_E:   phase_len = T_E;
      PH_HLD: phase_len = T_HLD;
      PH_NIB: phase_len = T_NIB;
      default: begin
        case (state_q)
          ST_PWR:  phase_len = T_PWR;
          ST_INIT: phase_len = (idx_q == 4'd0) ? T_4100 :
                               (idx_q == 4'd1) ? T_100  : T_CMD;
          ST_CMD:  phase_len = (cur_byte == 8'h01) ? T_CLR : T_CMD;
          default: phase_len = T_CMD;
        endcase
      end
    endcase
  end

  // Phase/step sequencing plus bus values; data/rs load only on entry to setup
  // so they hold between transactions.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    lo_d         = lo_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    snap_en      = 1'b0;
    if (cnt_q != CW'(phase_len - 32'd1)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
      case (ph_q)
        PH_SU:  ph_d = PH_E;
        PH_E:   ph_d = PH_HLD;
        PH_HLD: ph_d = (state_q == ST_INIT || lo_q) ? PH_WAIT : PH_NIB;
        PH_NIB: begin
          ph_d = PH_SU;
          lo_d = 1'b1;
        end
        default: begin
          ph_d = PH_SU;
          lo_d = 1'b0;
          case (state_q)
            ST_PWR: begin
              state_d = ST_INIT;
              idx_d   = '0;
            end
            ST_INIT: begin
              if (idx_q == 4'd3) begin
                state_d = ST_CMD;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 4'd1;
              end
            end
            ST_CMD: begin
              if (idx_q == 4'd3) begin
                state_d     = ST_ADDR1;
                idx_d       = '0;
                init_done_d = 1'b1;
                snap_en     = 1'b1;
              end else begin
                idx_d = idx_q + 4'd1;
              end
            end
            ST_ADDR1: state_d = ST_LINE1;
            ST_LINE1: begin
              idx_d = idx_q + 4'd1;
              if (idx_q == 4'd15) state_d = ST_ADDR2;
            end
            ST_ADDR2: state_d = ST_LINE2;
            ST_LINE2: begin
              idx_d = idx_q + 4'd1;
              if (idx_q == 4'd15) begin
                state_d      = ST_ADDR1;
                frame_done_d = 1'b1;
                snap_en      = 1'b1;
              end
            end
            default: begin
              state_d = ST_PWR;
              ph_d    = PH_WAIT;
              idx_d   = '0;
            end
          endcase
        end
      endcase
    end

    lcd_e_d  = (ph_d == PH_E);
    data_d   = data_q;
    rs_d     = rs_q;
    nxt_byte = byte_of(state_d, idx_d, snap1_q, snap2_q);
    if (ph_d == PH_SU && ph_q != PH_SU) begin
      data_d = lo_d ? nxt_byte[3:0] : nxt_byte[7:4];
      rs_d   = (state_d == ST_LINE1) || (state_d == ST_LINE2);
    end
  end

  // State, counters, outputs and the frame snapshot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_PWR;
      ph_q         <= PH_WAIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      lo_q         <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      lcd_e_q      <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= '0;
      snap1_q      <= '0;
      snap2_q      <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      lo_q         <= lo_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      lcd_e_q      <= lcd_e_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      if (snap_en) begin
        snap1_q <= string1;
        snap2_q <= string2;
      end
    end
  end

  assign lcd.lcd_e  = lcd_e_q;
  assign lcd.lcd_rs = rs_q;
  assign lcd.lcd_w  = 1'b0;
  assign lcd.data   = data_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_string_driver.sv
// Bench for lcd_string_driver: expected nibbles go into a queue as strings are
// driven; a bus monitor pops and compares on every lcd_e rise and checks
// strobe width, setup/hold, frame_done and init_done timing.
module tb_lcd_string_driver;

  localparam int unsigned T_PWR  = 100;
  localparam int unsigned T_4100 = 40;
  localparam int unsigned T_100  = 20;
  localparam int unsigned T_CMD  = 10;
  localparam int unsigned T_CLR  = 30;
  localparam int unsigned T_NIB  = 3;
  localparam int unsigned T_SU   = 2;
  localparam int unsigned T_E    = 4;
  localparam int unsigned T_HLD  = 2;
  localparam int unsigned NT     = T_SU + T_E + T_HLD;
  localparam int unsigned HI2LO  = NT + T_NIB;
  localparam int unsigned LO2HI  = NT + T_CMD;

  typedef struct packed {
    logic        rs;
    logic [3:0]  nib;
    logic [31:0] gap;
  } nib_t;

  typedef struct {
    logic [127:0] s1;
    logic [127:0] s2;
  } frame_vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] string1 = '0;
  logic [127:0] string2 = '0;
  logic         init_done, frame_done;

  lcd_string_driver_if lcd_bus();

  lcd_string_driver #(
    .T_PWR (T_PWR), .T_4100(T_4100), .T_100(T_100), .T_CMD(T_CMD),
    .T_CLR (T_CLR), .T_NIB (T_NIB),  .T_SU (T_SU),  .T_E  (T_E),
    .T_HLD (T_HLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .string1   (string1),
    .string2   (string2),
    .lcd       (lcd_bus),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  nib_t        exp_q[$];
  nib_t        init_tbl[12];
  frame_vec_t  fv[3];
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned cyc = 0, last_rst = 0, last_rise = 0, last_fall = 0;
  int          pulses_since_fd = 0;
  int          n_frame = 0;
  bit          chk_en = 1'b0;
  logic        prev_e = 1'b0, prev_fd = 1'b0, prev_id = 1'b0;
  logic [4:0]  prev_bus = '0, rise_bus = '0, cur_bus;
  int          stable_n = 0, width = 0, hold_left = 0;
  bit          moved = 1'b0, w_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b, input logic [31:0] gap);
    exp_q.push_back('{rs, b[7:4], gap});
    exp_q.push_back('{rs, b[3:0], HI2LO});
  endtask

  task automatic push_frame(input frame_vec_t v, input logic [31:0] first_gap);
    push_byte(1'b0, 8'h80, first_gap);
    for (int k = 0; k < 16; k++) push_byte(1'b1, v.s1[127-8*k -: 8], LO2HI);
    push_byte(1'b0, 8'hC0, LO2HI);
    for (int k = 0; k < 16; k++) push_byte(1'b1, v.s2[127-8*k -: 8], LO2HI);
  endtask

  task automatic push_init();
    for (int i = 0; i < 12; i++) exp_q.push_back(init_tbl[i]);
  endtask

  task automatic wait_cnt(input string what, input bit use_fd, input int target, input int budget);
    int k;
    k = 0;
    while (((use_fd ? pulses_since_fd : n_frame) < target) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(what, 32'((use_fd ? pulses_since_fd : n_frame) >= target), 32'd1);
  endtask

  // Edge counter; remembers the last edge that sampled reset asserted.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) last_rst = cyc;
  end

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    nib_t        e;
    int unsigned base;
    cur_bus = {lcd_bus.lcd_rs, lcd_bus.data};
    if (lcd_bus.lcd_w !== 1'b0) w_bad = 1'b1;
    if (cur_bus === prev_bus) stable_n++;
    else stable_n = 1;
    prev_bus = cur_bus;
    if (chk_en) begin
      if (lcd_bus.lcd_e && !prev_e) begin
        rise_bus = cur_bus;
        width    = 1;
        moved    = 1'b0;
        check("setup", 32'(stable_n >= int'(T_SU + 1)), 32'd1);
        base = (last_rst > last_rise) ? last_rst : last_rise;
        if (exp_q.size() == 0) begin
          check("pulse_expected", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rs", 32'(lcd_bus.lcd_rs), 32'(e.rs));
          check("nibble", 32'(lcd_bus.data), 32'(e.nib));
          check("rise_gap", cyc - base, e.gap);
        end
        last_rise = cyc;
        pulses_since_fd++;
      end else if (lcd_bus.lcd_e && prev_e) begin
        width++;
        if (cur_bus !== rise_bus) moved = 1'b1;
      end else if (!lcd_bus.lcd_e && prev_e) begin
        check("e_width", 32'(width), T_E);
        check("stable_high", 32'(moved), 32'd0);
        check("lcd_w", 32'(w_bad), 32'd0);
        hold_left = int'(T_HLD);
        last_fall = cyc;
      end
      if (!lcd_bus.lcd_e && hold_left > 0) begin
        check("hold", 32'(cur_bus), 32'(rise_bus));
        hold_left--;
      end
      if (frame_done) begin
        check("fd_single", 32'(prev_fd), 32'd0);
        check("fd_pulses", 32'(pulses_since_fd), 32'd68);
        check("fd_init", 32'(init_done), 32'd1);
        n_frame++;
        pulses_since_fd = 0;
      end
      if (init_done && !prev_id) begin
        check("init_done_delay", cyc - last_fall, T_HLD + T_CLR);
        check("init_pulses", 32'(pulses_since_fd), 32'd0);
      end
    end
    prev_e  = lcd_bus.lcd_e;
    prev_fd = frame_done;
    prev_id = init_done;
  end

  initial begin
    init_tbl[0]  = '{1'b0, 4'h3, T_PWR + T_SU};
    init_tbl[1]  = '{1'b0, 4'h3, NT + T_4100};
    init_tbl[2]  = '{1'b0, 4'h3, NT + T_100};
    init_tbl[3]  = '{1'b0, 4'h2, NT + T_CMD};
    init_tbl[4]  = '{1'b0, 4'h2, NT + T_CMD};
    init_tbl[5]  = '{1'b0, 4'h8, HI2LO};
    init_tbl[6]  = '{1'b0, 4'h0, LO2HI};
    init_tbl[7]  = '{1'b0, 4'h6, HI2LO};
    init_tbl[8]  = '{1'b0, 4'h0, LO2HI};
    init_tbl[9]  = '{1'b0, 4'hC, HI2LO};
    init_tbl[10] = '{1'b0, 4'h0, LO2HI};
    init_tbl[11] = '{1'b0, 4'h1, HI2LO};
    fv[0].s1 = "0011    0011    ";
    fv[0].s2 = {16{8'h41}};
    fv[1].s1 = {16{8'h5A}};
    fv[1].s2 = {16{8'h41}};
    fv[2].s1 = {16{8'h5A}};
    fv[2].s2 = "Hello, LCD 2024!";

    // Power-on reset with the first string pair in place.
    string1 = fv[0].s1;
    string2 = fv[0].s2;
    reset_n = 1'b0;
    push_init();
    push_frame(fv[0], NT + T_CLR);
    push_frame(fv[0], LO2HI);
    pulses_since_fd = -12;
    chk_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("reset_outs", 32'({lcd_bus.lcd_e, lcd_bus.lcd_rs, lcd_bus.lcd_w,
                               lcd_bus.data, init_done, frame_done}), 32'd0);
    end
    reset_n = 1'b1;

    // Change string1 while LINE1 character 5 of frame 2 is on the bus.
    wait_cnt("wait_frame1", 1'b0, 1, 3000);
    wait_cnt("wait_char5", 1'b1, 13, 2000);
    @(negedge clk);
    string1 = fv[1].s1;
    push_frame(fv[1], LO2HI);
    push_frame(fv[1], LO2HI);

    // Reset during the second high cycle of a LINE2 strobe in frame 4.
    wait_cnt("wait_frame3", 1'b0, 3, 3000);
    wait_cnt("wait_line2", 1'b1, 41, 2000);
    @(negedge clk);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_e", 32'(lcd_bus.lcd_e), 32'd0);
    check("midreset_init_done", 32'(init_done), 32'd0);
    check("midreset_bus", 32'({lcd_bus.lcd_rs, lcd_bus.data, frame_done}), 32'd0);
    @(negedge clk);
    exp_q.delete();
    string2 = fv[2].s2;
    pulses_since_fd = -12;
    push_init();
    push_frame(fv[2], NT + T_CLR);
    push_frame(fv[2], LO2HI);
    push_frame(fv[2], LO2HI);
    chk_en  = 1'b1;
    reset_n = 1'b1;

    wait_cnt("wait_frames_after_reset", 1'b0, 6, 5000);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
